vdp1_cmd_fetch: RTL and testbench

- Command-list walker that sits directly upstream of the VDP1 draw engines.
- Starts at VRAM address 0 on each plot start and reads 32-byte command tables from VRAM.
- Resolves the jump modes (next/assign/call/return/skip) and hands each non-skipped table to the draw/clip sequencer as one packed CMDTBL_t word with a valid/ready handshake.
- Maintains the COPR/LOPR/CEF status values exposed by the register block.

---
 rtl/vdp1_cmd_fetch.sv | 203 ++++++++++++++++++++
 tb/tb_vdp1_cmd_fetch.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp1_cmd_fetch.sv
// VDP1 command-list walker: fetches 32-byte command tables from VRAM, resolves
// the jump modes and hands each drawable table to the draw/clip sequencer.
module vdp1_cmd_fetch #(
  parameter logic [15:0] MAX_CMDS = 16'hFFFF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         START,
  input  logic         ABORT,
  output logic [17:0]  VRAM_A,
  output logic         VRAM_RD,
  input  logic [15:0]  VRAM_Q,
  input  logic         VRAM_RDY,
  output logic [255:0] CMD,
  output logic         CMD_VALID,
  input  logic         CMD_READY,
  output logic [15:0]  COPR,
  output logic [15:0]  LOPR,
  output logic         CEF,
  output logic         BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CTRL, S_RD_LINK, S_RD_BODY, S_PRESENT, S_NEXT, S_DONE
  } state_t;

  state_t      state_reg;
  logic [17:0] cur_addr_reg;
  logic [17:0] ret_addr_reg;
  logic        stack_valid_reg;
  logic [15:0] cmd_cnt_reg;
  logic [3:0]  word_idx_reg;
  logic [15:0] cmd_words_reg [16];
  logic [17:0] vram_a_reg;
  logic        vram_rd_reg;
  logic        cmd_valid_reg;
  logic [15:0] copr_reg;
  logic [15:0] lopr_reg;
  logic        cef_reg;

  logic        capture;
  logic [15:0] q_masked;
  logic [2:0]  jp;
  logic [17:0] seq_addr;
  logic [17:0] link_addr;
  logic [17:0] jump_addr;
  logic [17:0] word_next_addr;
  logic [15:0] cnt_next;

  // Reserved bits of the packed table read back as zero.
  function automatic logic [15:0] field_mask(input logic [3:0] idx);
    case (idx)
      4'd0:    field_mask = 16'hFF3F;
      4'd1:    field_mask = 16'hFFFC;
      4'd2:    field_mask = 16'h9FFF;
      4'd4:    field_mask = 16'hFFFC;
      4'd5:    field_mask = 16'h3FFF;
      default: field_mask = 16'hFFFF;
    endcase
  endfunction

  assign capture        = vram_rd_reg & VRAM_RDY;
  assign q_masked       = VRAM_Q & field_mask(word_idx_reg);
  assign jp             = cmd_words_reg[0][14:12];
  assign seq_addr       = cur_addr_reg + 18'd16;
  assign link_addr      = {cmd_words_reg[1], 2'b00};
  assign word_next_addr = cur_addr_reg + 18'(word_idx_reg) + 18'd1;
  assign cnt_next       = cmd_cnt_reg + 16'd1;

  always_comb begin
    case (jp[1:0])
      2'b01, 2'b10: jump_addr = link_addr;
      2'b11:        jump_addr = stack_valid_reg ? ret_addr_reg : seq_addr;
      default:      jump_addr = seq_addr;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= S_IDLE;
      cur_addr_reg    <= '0;
      ret_addr_reg    <= '0;
      stack_valid_reg <= 1'b0;
      cmd_cnt_reg     <= '0;
      word_idx_reg    <= '0;
      vram_a_reg      <= '0;
      vram_rd_reg     <= 1'b0;
      cmd_valid_reg   <= 1'b0;
      copr_reg        <= '0;
      lopr_reg        <= '0;
      cef_reg         <= 1'b0;
      for (int i = 0; i < 16; i++) cmd_words_reg[i] <= '0;
    end else if (CE) begin
      if (ABORT) begin
        state_reg     <= S_IDLE;
        vram_rd_reg   <= 1'b0;
        cmd_valid_reg <= 1'b0;
      end else begin
        // word_idx_reg always names the word currently being read.
        if (capture) cmd_words_reg[word_idx_reg] <= q_masked;
        case (state_reg)
          S_IDLE, S_DONE: begin
            if (START) begin
              cur_addr_reg    <= '0;
              cef_reg         <= 1'b0;
              cmd_cnt_reg     <= '0;
              stack_valid_reg <= 1'b0;
              copr_reg        <= '0;
              word_idx_reg    <= '0;
              vram_a_reg      <= '0;
              vram_rd_reg     <= 1'b1;
              state_reg       <= S_RD_CTRL;
            end
          end
          S_RD_CTRL: begin
            if (capture) begin
              if (VRAM_Q[15]) begin
                lopr_reg    <= cur_addr_reg[17:2];
                cef_reg     <= 1'b1;
                vram_rd_reg <= 1'b0;
                state_reg   <= S_DONE;
              end else begin
                word_idx_reg <= 4'd1;
                vram_a_reg   <= word_next_addr;
                state_reg    <= S_RD_LINK;
              end
            end
          end
          S_RD_LINK: begin
            if (capture) begin
              if (cmd_words_reg[0][14]) begin
                vram_rd_reg <= 1'b0;
                state_reg   <= S_NEXT;
              end else begin
                word_idx_reg <= 4'd2;
                vram_a_reg   <= word_next_addr;
                state_reg    <= S_RD_BODY;
              end
            end
          end
          S_RD_BODY: begin
            if (capture) begin
              if (word_idx_reg == 4'd15) begin
                vram_rd_reg   <= 1'b0;
                cmd_valid_reg <= 1'b1;
                state_reg     <= S_PRESENT;
              end else begin
                word_idx_reg <= word_idx_reg + 4'd1;
                vram_a_reg   <= word_next_addr;
              end
            end
          end
          S_PRESENT: begin
            if (CMD_READY) begin
              cmd_valid_reg <= 1'b0;
              state_reg     <= S_NEXT;
            end
          end
          S_NEXT: begin
            cmd_cnt_reg <= cnt_next;
            if (jp[1:0] == 2'b10) begin
              ret_addr_reg    <= seq_addr;
              stack_valid_reg <= 1'b1;
            end else if (jp[1:0] == 2'b11) begin
              stack_valid_reg <= 1'b0;
            end
            // The guard ends runaway link loops as if an END table was hit.
            if (cnt_next == MAX_CMDS) begin
              lopr_reg  <= copr_reg;
              cef_reg   <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              cur_addr_reg <= jump_addr;
              copr_reg     <= jump_addr[17:2];
              word_idx_reg <= '0;
              vram_a_reg   <= jump_addr;
              vram_rd_reg  <= 1'b1;
              state_reg    <= S_RD_CTRL;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cmd_word
      assign CMD[255-16*gi -: 16] = cmd_words_reg[gi];
    end
  endgenerate

  assign VRAM_A    = vram_a_reg;
  assign VRAM_RD   = vram_rd_reg;
  assign CMD_VALID = cmd_valid_reg;
  assign COPR      = copr_reg;
  assign LOPR      = lopr_reg;
  assign CEF       = cef_reg;
  assign BUSY      = (state_reg != S_IDLE) && (state_reg != S_DONE);

endmodule

// File: tb/tb_vdp1_cmd_fetch.sv
// Bench for vdp1_cmd_fetch: random VRAM latency, CE and backpressure, checked
// against a list-walking model of the command-table rules.
module tb_vdp1_cmd_fetch;

  localparam int MAXC   = 12;
  localparam int MAXC_G = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         RST = 1'b1, CE = 1'b1, START = 1'b0, ABORT = 1'b0;
  logic [17:0]  VRAM_A;
  logic         VRAM_RD;
  logic [15:0]  VRAM_Q = '0;
  logic         VRAM_RDY = 1'b0;
  logic [255:0] CMD;
  logic         CMD_VALID;
  logic         CMD_READY = 1'b1;
  logic [15:0]  COPR, LOPR;
  logic         CEF, BUSY;

  logic [17:0]  g_vram_a;
  logic         g_vram_rd, g_cmd_valid, g_cef, g_busy;
  logic [255:0] g_cmd;
  logic [15:0]  g_copr, g_lopr;

  vdp1_cmd_fetch #(.MAX_CMDS(16'(MAXC))) dut (
    .CLK(clk), .RST(RST), .CE(CE), .START(START), .ABORT(ABORT),
    .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_Q(VRAM_Q), .VRAM_RDY(VRAM_RDY),
    .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .COPR(COPR), .LOPR(LOPR), .CEF(CEF), .BUSY(BUSY)
  );

  // Twin with a tiny command guard; it sees identical inputs.
  vdp1_cmd_fetch #(.MAX_CMDS(16'(MAXC_G))) dut_g (
    .CLK(clk), .RST(RST), .CE(CE), .START(START), .ABORT(ABORT),
    .VRAM_A(g_vram_a), .VRAM_RD(g_vram_rd), .VRAM_Q(VRAM_Q), .VRAM_RDY(VRAM_RDY),
    .CMD(g_cmd), .CMD_VALID(g_cmd_valid), .CMD_READY(CMD_READY),
    .COPR(g_copr), .LOPR(g_lopr), .CEF(g_cef), .BUSY(g_busy)
  );

  int checks = 0, errors = 0;
  logic [15:0] vram [int];
  int ce_mode = 0, ready_mode = 0;
  int unsigned rdy_pct = 100;
  bit force_rdy = 1'b0;

  int           got_reads [$];
  logic [255:0] got_cmds [$];
  int           g_accepts = 0;
  int           exp_reads [$];
  logic [255:0] exp_cmds [$];
  logic [15:0]  exp_copr, exp_lopr;
  logic         exp_cef;

  function automatic logic [15:0] mrd(input int a);
    int k;
    k = a & 32'h3FFFF;
    return vram.exists(k) ? vram[k] : 16'h8000;
  endfunction

  function automatic logic [15:0] spec_mask(input int i);
    case (i)
      0: return 16'hFF3F;
      1: return 16'hFFFC;
      2: return 16'h9FFF;
      4: return 16'hFFFC;
      5: return 16'h3FFF;
      default: return 16'hFFFF;
    endcase
  endfunction

  // VRAM responder, CE and CMD_READY generator.
  always @(negedge clk) begin
    CE = (ce_mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (force_rdy || (VRAM_RD && ($urandom_range(1, 100) <= rdy_pct))) begin
      VRAM_RDY = 1'b1;
      VRAM_Q   = mrd(int'(VRAM_A));
    end else begin
      VRAM_RDY = 1'b0;
      VRAM_Q   = 16'($urandom);
    end
    case (ready_mode)
      0:       CMD_READY = 1'b1;
      1:       CMD_READY = 1'($urandom_range(0, 1));
      default: CMD_READY = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (CE && VRAM_RD && VRAM_RDY) got_reads.push_back(int'(VRAM_A));
    if (CE && CMD_VALID && CMD_READY) got_cmds.push_back(CMD);
    if (CE && g_cmd_valid && CMD_READY) g_accepts++;
  end

  // Walks the list the way the command-table rules describe it.
  task automatic model_walk(input int maxc);
    int cur, ret, nxt, n;
    bit sv;
    logic [15:0] ctrl, link, w;
    logic [2:0] jpm;
    logic [255:0] t;
    exp_reads.delete(); exp_cmds.delete();
    cur = 0; sv = 0; n = 0; exp_cef = 0;
    forever begin
      exp_copr = 16'(cur >> 2);
      ctrl = mrd(cur);
      exp_reads.push_back(cur);
      if (ctrl[15]) begin
        exp_lopr = 16'(cur >> 2); exp_cef = 1; break;
      end
      exp_reads.push_back((cur + 1) & 32'h3FFFF);
      link = mrd(cur + 1) & 16'hFFFC;
      jpm = ctrl[14:12];
      if (!jpm[2]) begin
        t = '0;
        for (int i = 0; i < 16; i++) begin
          w = mrd(cur + i) & spec_mask(i);
          if (i >= 2) exp_reads.push_back((cur + i) & 32'h3FFFF);
          t[255-16*i -: 16] = w;
        end
        exp_cmds.push_back(t);
      end
      case (jpm[1:0])
        2'b00: nxt = cur + 16;
        2'b01: nxt = int'(link) * 4;
        2'b10: begin ret = (cur + 16) & 32'h3FFFF; sv = 1; nxt = int'(link) * 4; end
        default: begin
          if (sv) begin nxt = ret; sv = 0; end
          else nxt = cur + 16;
        end
      endcase
      n++;
      if (n == maxc) begin
        exp_lopr = exp_copr; exp_cef = 1; break;
      end
      cur = nxt & 32'h3FFFF;
    end
  endtask

  task automatic put_table(input int w, input logic [15:0] ctrl, input logic [15:0] link);
    vram[w] = ctrl;
    vram[w + 1] = link;
    for (int i = 2; i < 16; i++) vram[w + i] = 16'($urandom);
  endtask

  task automatic start_list();
    got_reads.delete(); got_cmds.delete(); g_accepts = 0;
    @(negedge clk);
    START = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (CE) break;
    end
    @(negedge clk);
    START = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    ABORT = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (CE) break;
    end
    @(negedge clk);
    ABORT = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(CEF === 1'b1 && BUSY === 1'b0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL %s timeout: CEF=%b BUSY=%b, required CEF=1 BUSY=0", name, CEF, BUSY);
      pulse_abort();
    end
  endtask

  task automatic compare_list(input string name);
    checks++;
    if (got_reads.size() != exp_reads.size()) begin
      errors++;
      $display("FAIL %s read count: got %0d, expected %0d", name, got_reads.size(), exp_reads.size());
    end
    for (int i = 0; i < got_reads.size() && i < exp_reads.size(); i++) begin
      checks++;
      if (got_reads[i] !== exp_reads[i]) begin
        errors++;
        $display("FAIL %s read[%0d] addr: got %h, expected %h", name, i, got_reads[i], exp_reads[i]);
      end
    end
    checks++;
    if (got_cmds.size() != exp_cmds.size()) begin
      errors++;
      $display("FAIL %s table count: got %0d, expected %0d", name, got_cmds.size(), exp_cmds.size());
    end
    for (int i = 0; i < got_cmds.size() && i < exp_cmds.size(); i++) begin
      checks++;
      if (got_cmds[i] !== exp_cmds[i]) begin
        errors++;
        $display("FAIL %s table[%0d]: got %h, expected %h", name, i, got_cmds[i], exp_cmds[i]);
      end
    end
    checks++;
    if (COPR !== exp_copr || LOPR !== exp_lopr || CEF !== exp_cef) begin
      errors++;
      $display("FAIL %s status: got COPR=%h LOPR=%h CEF=%b, expected COPR=%h LOPR=%h CEF=%b",
               name, COPR, LOPR, CEF, exp_copr, exp_lopr, exp_cef);
    end
    $display("list %s: %0d reads, %0d tables, COPR=%h LOPR=%h", name, got_reads.size(),
             got_cmds.size(), COPR, LOPR);
  endtask

  task automatic run_list(input string name, input int maxc);
    model_walk(maxc);
    start_list();
    wait_done(name);
    compare_list(name);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (VRAM_A !== 18'd0 || VRAM_RD !== 1'b0 || CMD !== 256'd0 || CMD_VALID !== 1'b0 ||
        COPR !== 16'd0 || LOPR !== 16'd0 || CEF !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset: got A=%h RD=%b CMD=%h V=%b COPR=%h LOPR=%h CEF=%b BUSY=%b, expected all zero",
               VRAM_A, VRAM_RD, CMD, CMD_VALID, COPR, LOPR, CEF, BUSY);
    end
    RST = 1'b0;
    $display("reset: outputs sampled");
  endtask

  task automatic test_single();
    vram.delete();
    put_table(0, 16'h0004, 16'($urandom));
    vram[16] = 16'h8000;
    ce_mode = 0; ready_mode = 0; rdy_pct = 100;
    run_list("single", MAXC);
    checks++;
    if (got_reads.size() != 17 || got_cmds.size() != 1) begin
      errors++;
      $display("FAIL single counts: got %0d reads %0d tables, expected 17 and 1", got_reads.size(), got_cmds.size());
    end else begin
      checks++;
      if (got_cmds[0][255:240] !== 16'h0004 || got_reads[16] !== 32'h10) begin
        errors++;
        $display("FAIL single ctrl/addr: got %h / %h, expected 0004 / 10", got_cmds[0][255:240], got_reads[16]);
      end
    end
    checks++;
    if (LOPR !== 16'h0004 || COPR !== 16'h0004 || CEF !== 1'b1) begin
      errors++;
      $display("FAIL single status: got LOPR=%h COPR=%h CEF=%b, expected 0004 0004 1", LOPR, COPR, CEF);
    end
  endtask

  task automatic test_assign();
    vram.delete();
    put_table(0, 16'h1000, 16'h0010);
    vram[32'h40] = 16'h8000;
    run_list("assign", MAXC);
    checks++;
    if (got_reads.size() < 17 || got_reads[16] !== 32'h40 || COPR !== 16'h0010) begin
      errors++;
      $display("FAIL assign target: got %0d reads COPR=%h, expected read 16 at 40 and COPR=0010",
               got_reads.size(), COPR);
    end
  endtask

  task automatic test_call_return();
    vram.delete();
    put_table(0, 16'h2000, 16'h0008);
    put_table(32'h20, 16'h3000, 16'($urandom));
    put_table(32'h10, 16'h0000, 16'($urandom));
    vram[32'h30] = 16'h8000;
    run_list("call_return", MAXC);
    checks++;
    if (got_reads.size() != 65 || got_reads[32] !== 32'h10 || got_reads[48] !== 32'h20 ||
        got_reads[64] !== 32'h30) begin
      errors++;
      $display("FAIL call_return path: got %0d reads, expected 65 with tables at 10,20,30", got_reads.size());
    end
    checks++;
    if (COPR !== 16'h000C) begin
      errors++;
      $display("FAIL call_return COPR: got %h, expected 000c", COPR);
    end
  endtask

  task automatic test_skip();
    vram.delete();
    put_table(0, 16'h4000, 16'($urandom));
    vram[16] = 16'h8000;
    run_list("skip", MAXC);
    checks++;
    if (got_reads.size() != 3 || got_cmds.size() != 0 || got_reads[2] !== 32'h10) begin
      errors++;
      $display("FAIL skip: got %0d reads %0d tables, expected 3 reads ending at 10 and 0 tables",
               got_reads.size(), got_cmds.size());
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] snap;
    int n, bad;
    vram.delete();
    put_table(0, 16'h0005, 16'($urandom));
    vram[16] = 16'h8000;
    ready_mode = 2;
    model_walk(MAXC);
    start_list();
    n = 0;
    while (CMD_VALID !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    snap = CMD; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (CMD !== snap || VRAM_RD !== 1'b0 || CMD_VALID !== 1'b1) bad++;
    end
    checks++;
    if (n >= 2000 || bad != 0) begin
      errors++;
      $display("FAIL backpressure hold: got %0d unstable cycles (wait %0d), expected 0", bad, n);
    end
    ready_mode = 0;
    wait_done("backpressure");
    compare_list("backpressure");
  endtask

  task automatic test_abort();
    logic [15:0] saved_lopr;
    int n, bad;
    vram.delete();
    put_table(0, 16'h0001, 16'($urandom));
    vram[16] = 16'h8000;
    ce_mode = 0; ready_mode = 0; rdy_pct = 100;
    saved_lopr = LOPR;
    start_list();
    n = 0;
    while (got_reads.size() < 4 && n < 2000) begin @(negedge clk); n++; end
    ABORT = 1'b1;
    @(negedge clk);
    ABORT = 1'b0;
    checks++;
    if (BUSY !== 1'b0 || VRAM_RD !== 1'b0 || CMD_VALID !== 1'b0 || CEF !== 1'b0 || LOPR !== saved_lopr) begin
      errors++;
      $display("FAIL abort: got BUSY=%b RD=%b V=%b CEF=%b LOPR=%h, expected 0 0 0 0 %h",
               BUSY, VRAM_RD, CMD_VALID, CEF, LOPR, saved_lopr);
    end
    force_rdy = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (BUSY !== 1'b0 || VRAM_RD !== 1'b0 || CEF !== 1'b0) bad++;
    end
    force_rdy = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort late rdy: got %0d disturbed cycles, expected 0", bad);
    end
    run_list("after_abort", MAXC);
  endtask

  task automatic test_random();
    logic [15:0] ctrl, link;
    for (int it = 0; it < 8; it++) begin
      vram.delete();
      for (int s = 0; s < 16; s++) begin
        ctrl = 16'($urandom);
        ctrl[15] = ($urandom_range(0, 99) < 20);
        if ($urandom_range(0, 99) < 80) link = 16'($urandom_range(0, 15) * 4) | 16'($urandom_range(0, 3));
        else link = 16'($urandom);
        put_table(s * 16, ctrl, link);
      end
      ce_mode = 1; ready_mode = 1; rdy_pct = $urandom_range(30, 100);
      run_list($sformatf("random%0d", it), MAXC);
    end
    ce_mode = 0; ready_mode = 0; rdy_pct = 100;
  endtask

  task automatic test_loop_guard();
    RST = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    vram.delete();
    put_table(0, 16'h1000, 16'h0000);
    run_list("loop", MAXC);
    checks++;
    if (got_cmds.size() != MAXC) begin
      errors++;
      $display("FAIL loop main tables: got %0d, expected %0d", got_cmds.size(), MAXC);
    end
    checks++;
    if (g_accepts != MAXC_G || g_cef !== 1'b1 || g_lopr !== 16'h0000 || g_copr !== 16'h0000 || g_busy !== 1'b0) begin
      errors++;
      $display("FAIL loop guard4: got %0d tables CEF=%b LOPR=%h COPR=%h BUSY=%b, expected 4 1 0000 0000 0",
               g_accepts, g_cef, g_lopr, g_copr, g_busy);
    end
    $display("list loop_guard4: %0d tables, LOPR=%h", g_accepts, g_lopr);
  endtask

  initial begin
    test_reset();
    test_single();
    test_assign();
    test_call_return();
    test_skip();
    test_backpressure();
    test_abort();
    test_random();
    test_loop_guard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
